// File: rtl/graphics_pkg.sv
`default_nettype none
// ============================================================================
// Module : graphics_pkg
// Brief  : Shared pixel types, constants and layer-vector helpers.
// Rev    : 1.0  initial release
// ============================================================================
package graphics_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam logic [23:0] BLANK_RGB    = 24'h0;
    localparam int          PIPE_LATENCY = 2;
    localparam int          MAX_LAYERS   = 16;

    // Layer vectors are zero-extended to MAX_LAYERS slots before use.
    function automatic rgb_t unpack_layer(input logic [24*MAX_LAYERS-1:0] vec, input int idx);
        return rgb_t'(vec[24*idx +: 24]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alpha_blend_channel.sv
`default_nettype none
// ============================================================================
// Module : alpha_blend_channel
// Brief  : 8-bit alpha blend o = (W*a + P*(256-a)) >> 8, two registered stages.
// Rev    : 1.0  initial release
// ============================================================================
module alpha_blend_channel (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_alpha,
    input  logic [7:0] i_wall,
    input  logic [7:0] i_pix,
    output logic [7:0] o_blend
);

    logic [8:0]  w_inv_alpha;
    logic [16:0] r_prod_wall;
    logic [16:0] r_prod_pix;
    logic [16:0] w_sum;

    // 256-a needs 9 bits so that a=0 passes the pixel through exactly.
    assign w_inv_alpha = 9'd256 - {1'b0, i_alpha};
    assign w_sum       = r_prod_wall + r_prod_pix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod_wall <= '0;
            r_prod_pix  <= '0;
            o_blend     <= '0;
        end else begin
            r_prod_wall <= {9'd0, i_wall} * {9'd0, i_alpha};
            r_prod_pix  <= {9'd0, i_pix} * {8'd0, w_inv_alpha};
            o_blend     <= 8'(w_sum >> 8);
        end
    end

endmodule
`default_nettype wire

// File: rtl/layered_graphics_compositor.sv
`default_nettype none
// ============================================================================
// Module : layered_graphics_compositor
// Brief  : Two-stage pixel compositor: UI layers, collision flash, wall blend.
// Rev    : 1.0  initial release
// ============================================================================
module layered_graphics_compositor
    import graphics_pkg::*;
#(
    parameter int          NUM_LAYERS      = 4,
    parameter int          ACTIVE_H_PIXELS = 1280,
    parameter int          ACTIVE_LINES    = 720,
    parameter logic [23:0] COLLISION_COLOR = 24'h008000,
    parameter logic [23:0] FLASH_COLOR     = 24'hFFFFFF,
    parameter logic [23:0] WALL_COLOR      = 24'h00F000,
    parameter int          FLASH_FRAMES    = 30,
    parameter int          FLASH_PERIOD    = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [10:0]             hcount_in,
    input  logic [9:0]              vcount_in,
    input  logic                    frame_start_in,
    input  logic [NUM_LAYERS-1:0]   layer_valid_in,
    input  logic [24*NUM_LAYERS-1:0] layer_pixel_in,
    input  logic                    is_collision,
    input  logic                    is_wall,
    input  logic [7:0]              wall_alpha_in,
    input  logic [23:0]             pixel_in,
    output logic [23:0]             pixel_out,
    output logic [10:0]             hcount_out,
    output logic [9:0]              vcount_out,
    output logic                    active_out,
    output logic                    flashing_out
);

    localparam int                 c_cnt_w      = $clog2(FLASH_FRAMES + 1);
    localparam int                 c_ph_w       = $clog2(FLASH_PERIOD);
    localparam int                 c_ext_w      = 24 * MAX_LAYERS;
    localparam logic [10:0]        c_h_limit    = 11'(ACTIVE_H_PIXELS);
    localparam logic [9:0]         c_v_limit    = 10'(ACTIVE_LINES);
    localparam logic [c_cnt_w-1:0] c_flash_load = c_cnt_w'(FLASH_FRAMES);
    localparam logic [c_ph_w-1:0]  c_phase_last = c_ph_w'(FLASH_PERIOD - 1);

    logic [c_ext_w-1:0]  w_layers_ext;
    logic                w_active;
    logic                w_coll_hit;
    logic                w_blink_eff;
    logic                w_layer_hit;
    rgb_t                w_layer_rgb;
    rgb_t                w_sel_rgb;
    logic [7:0]          w_sel_alpha;

    logic [c_cnt_w-1:0]  r_flash_cnt;
    logic [c_ph_w-1:0]   r_phase_cnt;
    logic                r_blink_on;
    logic                r_coll_seen;
    logic [10:0]         r_hcount_s1;
    logic [9:0]          r_vcount_s1;
    logic                r_active_s1;
    logic                r_flashing_s1;

    assign w_layers_ext = c_ext_w'(layer_pixel_in);
    assign w_active     = (hcount_in < c_h_limit) && (vcount_in < c_v_limit);
    assign w_coll_hit   = is_collision && w_active;
    assign w_blink_eff  = r_blink_on && (r_flash_cnt != '0);

    // Walking from the top index down leaves the lowest valid index in place.
    always_comb begin
        w_layer_hit = 1'b0;
        w_layer_rgb = rgb_t'(BLANK_RGB);
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_valid_in[i]) begin
                w_layer_hit = 1'b1;
                w_layer_rgb = unpack_layer(w_layers_ext, i);
            end
        end
    end

    // Non-wall winners go through the blender with alpha 0, which returns P exactly.
    always_comb begin
        w_sel_alpha = 8'd0;
        w_sel_rgb   = rgb_t'(BLANK_RGB);
        if (w_active) begin
            if (w_layer_hit) begin
                w_sel_rgb = w_layer_rgb;
            end else if (is_collision) begin
                w_sel_rgb = w_blink_eff ? rgb_t'(FLASH_COLOR) : rgb_t'(COLLISION_COLOR);
            end else if (is_wall) begin
                w_sel_rgb   = rgb_t'(pixel_in);
                w_sel_alpha = wall_alpha_in;
            end else begin
                w_sel_rgb = rgb_t'(pixel_in);
            end
        end
    end

    for (genvar ch = 0; ch < 3; ch++) begin : g_channel
        alpha_blend_channel u_blend (
            .clk     (clk_in),
            .rst_n   (rst_n_in),
            .i_alpha (w_sel_alpha),
            .i_wall  (WALL_COLOR[8*ch +: 8]),
            .i_pix   (w_sel_rgb[8*ch +: 8]),
            .o_blend (pixel_out[8*ch +: 8])
        );
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_flash_cnt <= '0;
            r_phase_cnt <= '0;
            r_blink_on  <= 1'b0;
            r_coll_seen <= 1'b0;
        end else if (frame_start_in) begin
            // The first pixel already belongs to the new frame.
            r_coll_seen <= w_coll_hit;
            if (r_coll_seen) begin
                r_flash_cnt <= c_flash_load;
                r_phase_cnt <= '0;
                r_blink_on  <= 1'b1;
            end else if (r_flash_cnt != '0) begin
                r_flash_cnt <= r_flash_cnt - 1'b1;
                if (r_flash_cnt == c_cnt_w'(1)) begin
                    r_phase_cnt <= '0;
                    r_blink_on  <= 1'b0;
                end else if (r_phase_cnt == c_phase_last) begin
                    r_phase_cnt <= '0;
                    r_blink_on  <= ~r_blink_on;
                end else begin
                    r_phase_cnt <= r_phase_cnt + 1'b1;
                end
            end
        end else if (w_coll_hit) begin
            r_coll_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_hcount_s1   <= '0;
            r_vcount_s1   <= '0;
            r_active_s1   <= 1'b0;
            r_flashing_s1 <= 1'b0;
            hcount_out    <= '0;
            vcount_out    <= '0;
            active_out    <= 1'b0;
            flashing_out  <= 1'b0;
        end else begin
            r_hcount_s1   <= hcount_in;
            r_vcount_s1   <= vcount_in;
            r_active_s1   <= w_active;
            r_flashing_s1 <= (r_flash_cnt != '0);
            hcount_out    <= r_hcount_s1;
            vcount_out    <= r_vcount_s1;
            active_out    <= r_active_s1;
            flashing_out  <= r_flashing_s1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_layered_graphics_compositor.sv
`default_nettype none
// ============================================================================
// Module : tb_layered_graphics_compositor
// Brief  : Scoreboard bench for the layered graphics compositor.
// Rev    : 1.0  initial release
// ============================================================================
module tb_layered_graphics_compositor;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        frame_start_in;
    logic [3:0]  layer_valid_in;
    logic [95:0] layer_pixel_in;
    logic        is_collision;
    logic        is_wall;
    logic [7:0]  wall_alpha_in;
    logic [23:0] pixel_in;
    logic [23:0] pixel_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        active_out;
    logic        flashing_out;

    always #5 clk_in = ~clk_in;

    layered_graphics_compositor dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .frame_start_in (frame_start_in),
        .layer_valid_in (layer_valid_in),
        .layer_pixel_in (layer_pixel_in),
        .is_collision   (is_collision),
        .is_wall        (is_wall),
        .wall_alpha_in  (wall_alpha_in),
        .pixel_in       (pixel_in),
        .pixel_out      (pixel_out),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
        .active_out     (active_out),
        .flashing_out   (flashing_out)
    );

    typedef struct packed {
        logic [23:0] px;
        logic [10:0] h;
        logic [9:0]  v;
        logic        act;
        logic        fl;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   release_pending;
    bit   m_seen;
    bit   m_blink;
    int   m_flash;
    int   m_phase;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] blend8(input int w, input int p, input int a);
        int s;
        s = (w * a + p * (256 - a)) >> 8;
        return 8'(s);
    endfunction

    task automatic model_reset();
        sb_q.delete();
        m_seen  = 1'b0;
        m_blink = 1'b0;
        m_flash = 0;
        m_phase = 0;
    endtask

    task automatic step(input logic [10:0] h, input logic [9:0] v, input logic fs,
                        input logic [3:0] lv, input logic [95:0] lp, input logic coll,
                        input logic wall, input logic [7:0] alpha, input logic [23:0] pix);
        exp_t        e;
        logic        act;
        logic        hit;
        logic [23:0] ep;
        @(negedge clk_in);
        if (sb_q.size() >= 2) begin
            e = sb_q.pop_front();
            check("pixel_out", 32'(pixel_out), 32'(e.px));
            check("hcount_out", 32'(hcount_out), 32'(e.h));
            check("vcount_out", 32'(vcount_out), 32'(e.v));
            check("active_out", 32'(active_out), 32'(e.act));
            check("flashing_out", 32'(flashing_out), 32'(e.fl));
        end else begin
            check("fill_pixel", 32'(pixel_out), 32'd0);
            check("fill_active", 32'(active_out), 32'd0);
            check("fill_flashing", 32'(flashing_out), 32'd0);
        end
        if (release_pending) begin
            rst_n_in        = 1'b1;
            release_pending = 1'b0;
        end
        hcount_in      = h;
        vcount_in      = v;
        frame_start_in = fs;
        layer_valid_in = lv;
        layer_pixel_in = lp;
        is_collision   = coll;
        is_wall        = wall;
        wall_alpha_in  = alpha;
        pixel_in       = pix;

        act = (h < 11'd1280) && (v < 10'd720);
        ep  = 24'h0;
        if (!act) ep = 24'h0;
        else if (lv != 4'd0) begin
            for (int i = 3; i >= 0; i--) if (lv[i]) ep = lp[24*i +: 24];
        end else if (coll) ep = (m_blink && m_flash != 0) ? 24'hFFFFFF : 24'h008000;
        else if (wall) ep = {blend8(0, int'(pix[23:16]), int'(alpha)),
                             blend8(240, int'(pix[15:8]), int'(alpha)),
                             blend8(0, int'(pix[7:0]), int'(alpha))};
        else ep = pix;
        e.px  = ep;
        e.h   = h;
        e.v   = v;
        e.act = act;
        e.fl  = (m_flash != 0);
        sb_q.push_back(e);

        hit = coll && act;
        if (fs) begin
            if (m_seen) begin
                m_flash = 30;
                m_phase = 0;
                m_blink = 1'b1;
            end else if (m_flash > 0) begin
                m_flash--;
                if (m_phase == 3) begin
                    m_phase = 0;
                    m_blink = !m_blink;
                end else m_phase++;
            end
            m_seen = hit;
        end else if (hit) m_seen = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(11'd2000, 10'd0, 1'b0, 4'd0, 96'd0, 1'b0, 1'b0, 8'd0, 24'd0);
    endtask

    // Eight-pixel frame; pixel 7 is the last active pixel (1279,719), pixel 3 is the probe.
    task automatic frame(input bit probe, input bit last_coll, input bit first_coll);
        for (int p = 0; p < 8; p++) begin
            step((p == 7) ? 11'd1279 : 11'(p), (p == 7) ? 10'd719 : 10'd3, p == 0, 4'd0, 96'd0,
                 (p == 0 && first_coll) || (p == 3 && probe) || (p == 7 && last_coll),
                 1'b0, 8'd0, 24'h203040);
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n_in = 1'b0;
        #1;
        check("rst_pixel", 32'(pixel_out), 32'd0);
        check("rst_flashing", 32'(flashing_out), 32'd0);
        check("rst_active", 32'(active_out), 32'd0);
        check("rst_flash_cnt", 32'(dut.r_flash_cnt), 32'd0);
        model_reset();
        @(negedge clk_in);
        release_pending = 1'b1;
    endtask

    initial begin
        int k_list[5];
        rst_n_in        = 1'b0;
        hcount_in       = '0;
        vcount_in       = '0;
        frame_start_in  = 1'b0;
        layer_valid_in  = '0;
        layer_pixel_in  = '0;
        is_collision    = 1'b0;
        is_wall         = 1'b0;
        wall_alpha_in   = '0;
        pixel_in        = '0;
        release_pending = 1'b1;
        model_reset();
        k_list = '{1, 4, 5, 8, 9};

        // Priority: layer 1 beats layer 2, collision and wall; then bare collision.
        step(11'd10, 10'd5, 1'b0, 4'b0110, {24'h0, 24'h445566, 24'h112233, 24'h0},
             1'b1, 1'b1, 8'd128, 24'h00FF00);
        step(11'd11, 10'd5, 1'b0, 4'b0000, {24'h0, 24'h445566, 24'h112233, 24'h0},
             1'b1, 1'b0, 8'd0, 24'h00FF00);
        step(11'd12, 10'd5, 1'b0, 4'b1000, {24'hABCDEF, 72'd0}, 1'b0, 1'b1, 8'd9, 24'h0);

        // Wall blend at the alpha extremes, midpoint and random points.
        step(11'd20, 10'd6, 1'b0, 4'd0, 96'd0, 1'b0, 1'b1, 8'd0, 24'h00FF00);
        step(11'd21, 10'd6, 1'b0, 4'd0, 96'd0, 1'b0, 1'b1, 8'd128, 24'h00FF00);
        step(11'd22, 10'd6, 1'b0, 4'd0, 96'd0, 1'b0, 1'b1, 8'd255, 24'h00FF00);
        for (int i = 0; i < 6; i++)
            step(11'(30 + i), 10'd6, 1'b0, 4'd0, 96'd0, 1'b0, 1'b1,
                 8'($urandom_range(255)), 24'($urandom));

        // Blanking edges, and the last active pixel with a layer.
        step(11'd1280, 10'd5, 1'b0, 4'b0001, {72'd0, 24'hAABBCC}, 1'b0, 1'b1, 8'd200, 24'h123456);
        step(11'd5, 10'd720, 1'b0, 4'b0001, {72'd0, 24'hAABBCC}, 1'b0, 1'b1, 8'd200, 24'h123456);
        step(11'd1279, 10'd719, 1'b0, 4'b0001, {72'd0, 24'hAABBCC}, 1'b0, 1'b1, 8'd200, 24'h123456);

        // Collision seen above starts a flash; reset it mid-frame with the pipe full.
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        do_reset();
        frame(1'b0, 1'b0, 1'b0);

        // Blink phase sampled at frame N+k after a collision on the last active pixel.
        for (int j = 0; j < 5; j++) begin
            do_reset();
            frame(1'b0, 1'b1, 1'b0);
            for (int f = 1; f < k_list[j]; f++) frame(1'b0, 1'b0, 1'b0);
            frame(1'b1, 1'b0, 1'b0);
        end

        // Full flash duration with a retrigger at frame N+10.
        do_reset();
        frame(1'b0, 1'b1, 1'b0);
        for (int f = 1; f <= 45; f++) frame(f == 10, 1'b0, 1'b0);

        // Collision on the frame-start pixel belongs to the new frame.
        frame(1'b0, 1'b0, 1'b1);
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
